// File: rtl/sort_ctrl_pkg.sv
// Shared types and constants for the sort_ctrl sequencer.
// State encoding, swap counter width and a saturating increment.
package sort_ctrl_pkg;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam int SWAP_CNT_W = 8;

  typedef enum logic [1:0] {
    LOAD = ST_LOAD,
    SORT = ST_SORT,
    OUT  = ST_OUT
  } state_t;

  function automatic logic [SWAP_CNT_W-1:0] sat_inc(
    input logic [SWAP_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sort_ctrl_if.sv
// Producer/consumer valid-ready streams of the sort controller.
// master drives words in and accepts sorted words; slave is the sorter.
interface sort_ctrl_if #(
  parameter int W = 4
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sort_ctrl_mag_cmp.sv
// Unsigned W-bit magnitude comparator, the one shared compare resource.
// gt is high when a is strictly greater than b.
module mag_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt
);

  assign gt = a > b;

endmodule

// File: rtl/sort_ctrl.sv
// Burst sorter: load N words, bubble sort through one comparator,
// then stream them out smallest first.
module sort_ctrl
  import sort_ctrl_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sort_ctrl_if.slave            bus,
  output logic                  busy,
  output logic                  done,
  output logic [SWAP_CNT_W-1:0] swap_cnt
);

  localparam int IW = $clog2(N) + 1;
  localparam int AW = $clog2(N);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);
  localparam logic [IW-1:0] SLAST = IW'(N - 2);

  state_t state, state_n;

  logic [IW-1:0] wr_idx, rd_idx, pass, idx, idx1;
  logic [W-1:0]  mem [N];
  logic [W-1:0]  a, b;
  logic          gt;
  logic          in_xfer, out_xfer;
  logic          load_end, sort_end, out_end;

  assign idx1 = idx + 1'b1;
  assign a    = mem[idx[AW-1:0]];
  assign b    = mem[idx1[AW-1:0]];

  mag_cmp #(.W(W)) u_cmp (
    .a (a),
    .b (b),
    .gt(gt)
  );

  assign bus.in_ready  = (state == LOAD) & ~reset;
  assign bus.out_valid = (state == OUT) & ~reset;
  assign bus.out_data  = mem[rd_idx[AW-1:0]];
  assign busy          = state != LOAD;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;
  assign load_end = in_xfer & (wr_idx == LAST);
  assign sort_end = (state == SORT) & (idx == SLAST) & (pass == SLAST);
  assign out_end  = out_xfer & (rd_idx == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      (state == LOAD): if (load_end) state_n = SORT;
      (state == SORT): if (sort_end) state_n = OUT;
      (state == OUT):  if (out_end)  state_n = LOAD;
      default:         state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      pass     <= '0;
      idx      <= '0;
      swap_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= out_end;
      if (in_xfer) begin
        wr_idx <= load_end ? '0 : wr_idx + 1'b1;
      end
      if (load_end) begin
        pass     <= '0;
        idx      <= '0;
        swap_cnt <= '0;
      end
      if (state == SORT) begin
        if (gt) swap_cnt <= sat_inc(swap_cnt);
        if (idx == SLAST) begin
          idx  <= '0;
          pass <= sort_end ? '0 : pass + 1'b1;
        end else begin
          idx <= idx1;
        end
      end
      if (sort_end) rd_idx <= '0;
      if (out_xfer) begin
        rd_idx <= out_end ? '0 : rd_idx + 1'b1;
      end
    end
  end

  // Ties are left in place so the sort stays stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (in_xfer) begin
      mem[wr_idx[AW-1:0]] <= bus.in_data;
    end else if ((state == SORT) && gt) begin
      mem[idx[AW-1:0]]  <= b;
      mem[idx1[AW-1:0]] <= a;
    end
  end

endmodule

// File: tb/tb_sort_ctrl.sv
// Directed plus random bursts for sort_ctrl against a sorted-list
// and inversion-count reference.
module tb_sort_ctrl;

  localparam int W = 4;
  localparam int N = 4;

  typedef logic [W-1:0] word_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy, done;
  logic [7:0] swap_cnt;

  sort_ctrl_if #(.W(W)) bus ();

  sort_ctrl #(.W(W), .N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .swap_cnt(swap_cnt)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  word_t v [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bubble sort swaps exactly the inverted pairs.
  function automatic int inversions(input word_t w [N]);
    int c = 0;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (w[i] > w[j]) c++;
    return c;
  endfunction

  function automatic void model_sort(input word_t w [N],
                                     output word_t s [N]);
    word_t t;
    s = w;
    for (int i = 1; i < N; i++)
      for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
        t = s[j]; s[j] = s[j-1]; s[j-1] = t;
      end
  endfunction

  task automatic load_words(input word_t w [N]);
    int guard;
    for (int i = 0; i < N; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w[i];
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
        tick();
        guard++;
      end
      chk("in_ready", bus.in_ready, 1);
      tick();
      if (i == 0) chk("done_low", done, 0);
    end
  endtask

  task automatic load_sort(input word_t w [N]);
    int sc = 0;
    load_words(w);
    bus.in_data = 4'hA;
    while (!bus.out_valid && sc < 100) begin
      chk("sort_flags", {bus.in_ready, busy}, 2'b01);
      sc++;
      tick();
    end
    chk("sort_cycles", sc, (N - 1) * (N - 1));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input word_t w [N], input int mode);
    word_t s [N];
    int k = 0;
    int cyc = 0;
    model_sort(w, s);
    while (k < N && cyc < 200) begin
      chk("out_valid", bus.out_valid, 1);
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc >= 5) && (cyc % 2 == 1);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      chk($sformatf("out_data%0d", k), bus.out_data, s[k]);
      if (bus.out_ready) k++;
      cyc++;
      tick();
    end
    chk("out_count", k, N);
    if (mode == 0) chk("out_cycles", cyc, N);
    chk("done", done, 1);
    chk("done_in_ready", bus.in_ready, 1);
    chk("done_out_valid", bus.out_valid, 0);
    chk("done_busy", busy, 0);
    chk("swap_cnt", swap_cnt, inversions(w));
  endtask

  task automatic burst(input word_t w [N], input int mode,
                       input bit gap);
    load_sort(w);
    drain(w, mode);
    if (gap) begin
      tick();
      chk("done_pulse", done, 0);
      chk("swap_hold", swap_cnt, inversions(w));
      chk("idle_busy", busy, 0);
      chk("idle_in_ready", bus.in_ready, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_swap", swap_cnt, 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", bus.in_ready, 1);

    v = '{4'd1, 4'd14, 4'd11, 4'd15};
    burst(v, 0, 1'b1);
    v = '{4'd15, 4'd14, 4'd11, 4'd1};
    burst(v, 0, 1'b1);
    v = '{4'd15, 4'd15, 4'd0, 4'd0};
    burst(v, 0, 1'b1);
    v = '{4'd7, 4'd7, 4'd7, 4'd7};
    burst(v, 0, 1'b1);
    v = '{4'd9, 4'd3, 4'd12, 4'd5};
    burst(v, 1, 1'b1);

    v = '{4'd5, 4'd3, 4'd9, 4'd1};
    load_words(v);
    bus.in_valid = 1'b0;
    repeat (3) tick();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_swap", swap_cnt, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_post_in_ready", bus.in_ready, 1);
    chk("mid_post_busy", busy, 0);
    chk("mid_post_swap", swap_cnt, 0);
    v = '{4'd6, 4'd2, 4'd9, 4'd0};
    burst(v, 0, 1'b1);

    v = '{4'd3, 4'd8, 4'd1, 4'd8};
    burst(v, 0, 1'b0);
    v = '{4'd10, 4'd4, 4'd4, 4'd2};
    burst(v, 0, 1'b1);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, 15));
      burst(v, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_ctrl.md
Name: sort_ctrl

Overview:
- Sequential sorting controller that time-shares one W-bit magnitude comparator (A > B, unsigned) to sort a burst of N words in ascending order.
- Accepts N words over a valid/ready input stream and runs a fixed-length bubble sort, one compare/swap per cycle.
- Returns the sorted words over a valid/ready output stream.
- Sits between a producer and a consumer in the P0 datapath exercises. It is the sequencer for the comparator datapath.

Parameters:
- W, 4, data word width in bits.
- N, 4, words per burst; legal range 2..8.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has in_data.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  W  word to load.
- out_valid  output  1  out_data holds a sorted word.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  W  sorted word, smallest first.
- busy  output  1  high in SORT and OUT.
- done  output  1  one-cycle pulse after the last output transfer.
- swap_cnt  output  8  number of swaps performed in the current or last sort.

Behaviour:
- One clock, clk. reset is asynchronous and active-high.
- Reset effects:
  - state=LOAD; all counters 0; mem[0..N-1]=0; swap_cnt=0; done=0.
  - in_ready and out_valid are forced 0 while reset is high.
- States: LOAD -> SORT -> OUT -> LOAD.
- LOAD:
  - in_ready=1, out_valid=0, busy=0.
  - A transfer (in_valid & in_ready) writes mem[wr_idx]=in_data, then wr_idx++.
  - On the transfer with wr_idx==N-1: go to SORT next cycle, clear swap_cnt, clear pass/idx.
  - in_valid with no room does not occur; in_ready is 0 outside LOAD, and data offered then is ignored.
- SORT:
  - in_ready=0, out_valid=0, busy=1.
  - Each cycle, the shared comparator sees A=mem[idx], B=mem[idx+1].
  - If gt=1, swap the two entries and increment swap_cnt (saturating at 255).
  - Equal values are never swapped, so the sort is stable.
  - idx runs 0..N-2 within a pass; pass runs 0..N-2. No early exit.
  - Duration is exactly (N-1)*(N-1) cycles (9 for N=4).
  - After the last compare cycle: go to OUT, rd_idx=0.
- Latency: if the last input transfers at edge t, the SORT cycles are edges t+1..t+(N-1)^2. out_valid is first high in the cycle after edge t+(N-1)^2; for N=4 that is the cycle after t+9.
- OUT:
  - out_valid=1, out_data=mem[rd_idx], busy=1.
  - A transfer (out_valid & out_ready) increments rd_idx.
  - With out_ready=0, out_data and rd_idx hold stable, for any number of cycles.
  - On the transfer with rd_idx==N-1: go to LOAD and pulse done=1 for exactly the following cycle.
  - A new burst may transfer in that same done cycle.
- swap_cnt: holds its value through OUT and the following LOAD until the next SORT entry clears it.
- Reset mid-operation, in any state: immediate return to LOAD with reset values. A partially loaded or partially output burst is discarded.
- Arithmetic:
  - Comparison is unsigned on W bits.
  - Index counters are ceil(log2(N))+1 bits wide; no wrap-around is reachable because terminal counts are explicit.

Decomposition:
- Package sort_ctrl_pkg:
  - State encoding constants ST_LOAD=2'd0, ST_SORT=2'd1, ST_OUT=2'd2.
  - SWAP_CNT_W=8.
- One sub-module: mag_cmp, parameter W; combinational, inputs A and B, output gt = (A > B) unsigned.
  - It is instantiated once and driven by the idx mux; this is the shared resource.
- The FSM, counters and register file stay in sort_ctrl.

Test Plan:
- Reset then load 1,14,11,15 with in_valid held high and out_ready=1.
  - Expect in_ready low for exactly 9 cycles after the 4th transfer.
  - Expect outputs 1,11,14,15 on consecutive cycles, swap_cnt=1, done high one cycle after the 15 transfers.
- Load 15,14,11,1 (reverse order) -> outputs 1,11,14,15, swap_cnt=6.
- Load 15,15,0,0 -> outputs 0,0,15,15, swap_cnt=4. Load 7,7,7,7 -> outputs 7,7,7,7, swap_cnt=0.
- Backpressure: out_ready=0 for 5 cycles at OUT entry, then toggled every other cycle.
  - Expect out_data=mem[0] held stable while stalled, with no lost or duplicated words.
  - Order is still ascending; done pulses once.
- Assert reset for 1 cycle in the 4th SORT cycle.
  - Expect in_ready=0 during reset and 1 in the next cycle, busy=0, swap_cnt=0.
  - A fresh load of 6,2,9,0 then yields 0,2,6,9.
- Back-to-back bursts: present the second burst's first word in the done cycle.
  - Expect it accepted in that cycle and both bursts sorted correctly.
